// File: rtl/sqrt_arb_pkg.sv
// sqrt_arb_pkg: shared state encoding, default widths and the error result
// for the round-robin square-root arbiter (sqrt_arbiter, sqrt_arb_rr_pick).
package sqrt_arb_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_ISSUE = 4'b0010,
    S_WAIT  = 4'b0100,
    S_RESP  = 4'b1000
  } state_t;

  localparam int SQRT_XW = 32;
  localparam int SQRT_YW = 16;

  localparam logic [SQRT_YW-1:0] SQRT_ERR_Y = '1;

endpackage

// File: rtl/sqrt_arb_rr_pick.sv
// sqrt_arb_rr_pick: combinational round-robin picker.
// Ports: req (request vector), ptr (search start) -> gnt (one-hot), idx, any.
module sqrt_arb_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDW-1:0]   idx,
  output logic             any
);

  logic [IDW-1:0] pos;
  int             j;

  // Walk upward from ptr, wrapping at N_REQ; the first set bit wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = '0;
    j   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      pos = IDW'(j);
      if (!any && req[pos]) begin
        any      = 1'b1;
        idx      = pos;
        gnt[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter: round-robin share of one iterative sqrt engine by N_REQ clients.
// Ports: clk, rst (async high); req_vld/req_x/req_rdy request side;
// rsp_vld/rsp_y/rsp_id/rsp_err response pulse; eng_vld_in/eng_x start,
// eng_vld_out/eng_y done; busy. Optional SQRT_ARB_TIMEOUT_EN: WAIT watchdog.
module sqrt_arbiter
  import sqrt_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int IDW         = $clog2(N_REQ),
  parameter int XW          = SQRT_XW,
  parameter int YW          = SQRT_YW,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_vld,
  input  logic [N_REQ*XW-1:0] req_x,
  output logic [N_REQ-1:0]    req_rdy,
  output logic [N_REQ-1:0]    rsp_vld,
  output logic [YW-1:0]       rsp_y,
  output logic [IDW-1:0]      rsp_id,
  output logic                rsp_err,
  output logic                eng_vld_in,
  output logic [XW-1:0]       eng_x,
  input  logic                eng_vld_out,
  input  logic [YW-1:0]       eng_y,
  output logic                busy
);

  state_t         state, state_nx;
  logic [IDW-1:0] ptr, ptr_nx;
  logic [IDW-1:0] id_r, id_nx;
  logic [XW-1:0]  x_r, x_nx, x_sel;
  logic [YW-1:0]  y_r, y_nx;
  logic           err_r, err_nx;

  logic [N_REQ-1:0] gnt;
  logic [IDW-1:0]   g_idx;
  logic             g_any;
  logic             tmo;

  sqrt_arb_rr_pick #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_pick (
    .req (req_vld),
    .ptr (ptr),
    .gnt (gnt),
    .idx (g_idx),
    .any (g_any)
  );

  always_comb begin
    x_sel = '0;
    for (int i = 0; i < N_REQ; i++)
      if (gnt[i]) x_sel = req_x[i*XW +: XW];
  end

`ifdef SQRT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;

  // Zero outside WAIT, so it is clear on the first WAIT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  cnt <= '0;
    else if (state != S_WAIT) cnt <= '0;
    else                      cnt <= cnt + CW'(1);
  end

  // Fires on the TIMEOUT_CYC-th WAIT cycle.
  assign tmo = (state == S_WAIT) && (cnt == CW'(TIMEOUT_CYC - 1));
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYC;
  assign tmo            = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    id_nx    = id_r;
    x_nx     = x_r;
    y_nx     = y_r;
    err_nx   = err_r;
    unique case (1'b1)
      state[0]: begin
        if (g_any) begin
          x_nx   = x_sel;
          id_nx  = g_idx;
          err_nx = 1'b0;
          if (x_sel[XW-1:1] == '0) begin
            y_nx     = {{(YW-1){1'b0}}, x_sel[0]};
            state_nx = S_RESP;
          end else begin
            state_nx = S_ISSUE;
          end
        end
      end
      state[1]: state_nx = S_WAIT;
      state[2]: begin
        if (eng_vld_out) begin
          y_nx     = eng_y;
          err_nx   = 1'b0;
          state_nx = S_RESP;
        end else if (tmo) begin
          y_nx     = {YW{1'b1}};
          err_nx   = 1'b1;
          state_nx = S_RESP;
        end
      end
      state[3]: begin
        ptr_nx   = (id_r == IDW'(N_REQ - 1)) ? '0 : id_r + IDW'(1);
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      ptr   <= '0;
      id_r  <= '0;
      x_r   <= '0;
      y_r   <= '0;
      err_r <= 1'b0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      id_r  <= id_nx;
      x_r   <= x_nx;
      y_r   <= y_nx;
      err_r <= err_nx;
    end
  end

  // rst gating keeps req_rdy quiet while reset is held.
  assign req_rdy    = (state == S_IDLE && !rst) ? gnt : '0;
  assign eng_vld_in = (state == S_ISSUE);
  assign eng_x      = (state == S_ISSUE || state == S_WAIT) ? x_r : '0;
  assign busy       = (state != S_IDLE);

  always_comb begin
    rsp_vld = '0;
    for (int i = 0; i < N_REQ; i++)
      rsp_vld[i] = (state == S_RESP) && (id_r == IDW'(i));
  end

  assign rsp_y   = (state == S_RESP) ? y_r   : '0;
  assign rsp_id  = (state == S_RESP) ? id_r  : '0;
  assign rsp_err = (state == S_RESP) ? err_r : 1'b0;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// tb_sqrt_arbiter: randomized + directed bench for sqrt_arbiter with a
// timestamp-based reference model and a simple delayed-reply engine.
module tb_sqrt_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int XW  = 32;
  localparam int YW  = 16;
  localparam int TO  = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_vld, req_rdy, rsp_vld;
  logic [N*XW-1:0] req_x;
  logic [YW-1:0]   rsp_y, eng_y;
  logic [IDW-1:0]  rsp_id;
  logic            rsp_err, eng_vld_in, eng_vld_out, busy;
  logic [XW-1:0]   eng_x;

  sqrt_arbiter #(
    .N_REQ(N), .IDW(IDW), .XW(XW), .YW(YW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_x(req_x), .req_rdy(req_rdy),
    .rsp_vld(rsp_vld), .rsp_y(rsp_y), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .eng_vld_in(eng_vld_in), .eng_x(eng_x),
    .eng_vld_out(eng_vld_out), .eng_y(eng_y), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // requester / engine environment
  bit          pend[N], keep[N], outst[N], acc_flag[N];
  logic [31:0] px[N];
  bit          auto_en = 0, spur_en = 0, eng_dead = 0;
  int          eng_fix = 3;
  int          reply_at = -1;
  logic [15:0] reply_y;
  int          n_issue = 0;

  // reference model
  bit          m_act = 0, m_byp, m_err;
  int          m_ptr = 0, m_id, m_acc, m_rsp_at;
  logic [31:0] m_x;
  logic [15:0] m_y;
  int          n_rsp = 0;

  // observed DUT activity
  int act_id[$], act_y[$], act_err[$];
  int acc_cyc, iss_cyc, rsp_cyc;
  logic [N-1:0] acc_rdy;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] isqrt(logic [31:0] x);
    longint lo, hi, m, xx;
    xx = longint'(x);
    lo = 0;
    hi = 65535;
    while (lo < hi) begin
      m = (lo + hi + 1) / 2;
      if (m * m <= xx) lo = m;
      else hi = m - 1;
    end
    return 16'(lo);
  endfunction

  function automatic int rr_pick(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [31:0] rand_x();
    logic [31:0] r;
    case ($urandom_range(0, 3))
      0: r = 32'($urandom_range(0, 3));
      1: begin r = 32'($urandom_range(0, 65535)); r = r * r; end
      2: r = 32'hFFFF_FFFF;
      default: r = $urandom;
    endcase
    return r;
  endfunction

  // input driver: one update per cycle, 1 time unit after the edge
  initial begin
    req_vld = '0;
    req_x = '0;
    eng_vld_out = 1'b0;
    eng_y = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc_flag[i]) begin
          acc_flag[i] = 0;
          pend[i] = 0;
          if (keep[i]) begin pend[i] = 1; px[i] = rand_x(); end
        end else if (auto_en && !pend[i] && !outst[i] &&
                     $urandom_range(0, 3) == 0) begin
          pend[i] = 1;
          px[i] = rand_x();
        end
        req_vld[i] = pend[i];
        req_x[i*XW +: XW] = px[i];
      end
      if (!eng_dead && reply_at == cyc) begin
        eng_vld_out = 1'b1;
        eng_y = reply_y;
        reply_at = -1;
      end else if (spur_en && $urandom_range(0, 15) == 0) begin
        eng_vld_out = 1'b1;
        eng_y = 16'($urandom);
      end else begin
        eng_vld_out = 1'b0;
        eng_y = 16'($urandom);
      end
    end
  end

  // compare process + model advance, on the falling edge
  initial begin
    logic [N-1:0]  e_rdy, e_rv;
    logic [XW-1:0] e_ex;
    logic [YW-1:0] e_ry;
    logic          e_ev, e_err, e_busy;
    int            e_rid, g;
    bit            do_acc, do_fin;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_act = 0;
        m_ptr = 0;
        chk("reset_out",
            {3'b0, req_rdy, rsp_vld, rsp_y, rsp_id, rsp_err,
             eng_vld_in, eng_x, busy}, 64'd0);
      end else begin
        e_rdy = '0; e_rv = '0; e_ex = '0; e_ry = '0;
        e_ev = 0; e_err = 0; e_busy = 0; e_rid = 0; g = 0;
        do_acc = 0; do_fin = 0;
        if (!m_act) begin
          if (req_vld != '0) begin
            g = rr_pick(req_vld, m_ptr);
            e_rdy[g] = 1'b1;
            do_acc = 1;
          end
        end else begin
          e_busy = 1;
          if (cyc == m_acc + 1 && !m_byp) begin
            e_ev = 1;
            e_ex = m_x;
          end else if (cyc == m_rsp_at) begin
            e_rv[m_id] = 1'b1;
            e_ry = m_y;
            e_rid = m_id;
            e_err = m_err;
            do_fin = 1;
          end else begin
            e_ex = m_x;
            if (m_rsp_at < 0) begin
              if (eng_vld_out) begin
                m_rsp_at = cyc + 1;
                m_y = eng_y;
                m_err = 0;
              end
`ifdef SQRT_ARB_TIMEOUT_EN
              else if (cyc == m_acc + 1 + TO) begin
                m_rsp_at = cyc + 1;
                m_y = 16'hFFFF;
                m_err = 1;
              end
`endif
            end
          end
        end
        chk("req_rdy", 64'(req_rdy), 64'(e_rdy));
        chk("eng_vld_in", 64'(eng_vld_in), 64'(e_ev));
        chk("eng_x", 64'(eng_x), 64'(e_ex));
        chk("rsp_vld", 64'(rsp_vld), 64'(e_rv));
        chk("rsp_y", 64'(rsp_y), 64'(e_ry));
        chk("rsp_id", 64'(rsp_id), 64'(e_rid));
        chk("rsp_err", 64'(rsp_err), 64'(e_err));
        chk("busy", 64'(busy), 64'(e_busy));
        if (do_acc) begin
          m_act = 1;
          m_id = g;
          m_x = px[g];
          m_acc = cyc;
          m_byp = (px[g] < 2);
          m_rsp_at = m_byp ? cyc + 1 : -1;
          m_y = {15'd0, px[g][0]};
          m_err = 0;
          acc_flag[g] = 1;
          outst[g] = 1;
        end
        if (do_fin) begin
          m_act = 0;
          m_ptr = (m_id + 1) % N;
          outst[m_id] = 0;
          n_rsp++;
        end
      end
      // environment reactions to the DUT
      if (!rst && eng_vld_in) begin
        n_issue++;
        iss_cyc = cyc;
        if (!eng_dead) begin
          reply_at = cyc + ((eng_fix > 0) ? eng_fix : $urandom_range(1, 20));
          reply_y = isqrt(eng_x);
        end
      end
      if (!rst && req_rdy != '0) begin
        acc_cyc = cyc;
        acc_rdy = req_rdy;
      end
      if (!rst && rsp_vld != '0) begin
        rsp_cyc = cyc;
        act_id.push_back(int'(rsp_id));
        act_y.push_back(int'(rsp_y));
        act_err.push_back(int'(rsp_err));
      end
    end
  end

  task automatic clear_obs();
    act_id.delete();
    act_y.delete();
    act_err.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1;
    auto_en = 0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 0; keep[i] = 0; outst[i] = 0; acc_flag[i] = 0;
    end
    @(posedge clk);
    #2;
    rst = 0;
  endtask

  task automatic wait_rsp(int target, int budget, string nm);
    int k;
    k = 0;
    while (n_rsp < target && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(nm, 64'(n_rsp >= target), 64'd1);
  endtask

  initial begin
    int base, n0, k;
    rst = 1;
    for (int i = 0; i < N; i++) begin
      pend[i] = 0; keep[i] = 0; outst[i] = 0; acc_flag[i] = 0; px[i] = '0;
    end
    chk("model_isqrt144", 64'(isqrt(32'd144)), 64'd12);
    chk("model_isqrt_max", 64'(isqrt(32'hFFFF_FFFF)), 64'd65535);
    chk("model_isqrt99", 64'(isqrt(32'd99)), 64'd9);
    chk("model_rr", 64'(rr_pick(4'b1001, 1)), 64'd3);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 0;

    // 1: requester 2, x=144, 17-cycle engine
    clear_obs();
    eng_fix = 17;
    base = n_rsp;
    px[2] = 32'd144;
    pend[2] = 1;
    wait_rsp(base + 1, 60, "t1_done");
    chk("t1_rdy", 64'(acc_rdy), 64'h4);
    chk("t1_issue_lat", 64'(iss_cyc - acc_cyc), 64'd1);
    chk("t1_rsp_lat", 64'(rsp_cyc - acc_cyc), 64'd19);
    chk("t1_y", 64'(act_y[0]), 64'd12);
    chk("t1_id", 64'(act_id[0]), 64'd2);

    // 2: all four at once from reset
    do_reset();
    clear_obs();
    eng_fix = 3;
    base = n_rsp;
    px[0] = 32'd100; px[1] = 32'd81; px[2] = 32'hFFFF_FFFF; px[3] = 32'd2;
    for (int i = 0; i < N; i++) pend[i] = 1;
    wait_rsp(base + 4, 100, "t2_done");
    for (int i = 0; i < 4; i++) chk("t2_order", 64'(act_id[i]), 64'(i));
    chk("t2_y0", 64'(act_y[0]), 64'd10);
    chk("t2_y1", 64'(act_y[1]), 64'd9);
    chk("t2_y2", 64'(act_y[2]), 64'd65535);
    chk("t2_y3", 64'(act_y[3]), 64'd1);
    px[3] = 32'd9; px[0] = 32'd16;
    pend[3] = 1; pend[0] = 1;
    wait_rsp(base + 6, 60, "t2_wrap_done");
    chk("t2_wrap0", 64'(act_id[4]), 64'd0);
    chk("t2_wrap1", 64'(act_id[5]), 64'd3);

    // 3: bypass on requester 3
    clear_obs();
    n0 = n_issue;
    base = n_rsp;
    px[3] = 32'd0;
    pend[3] = 1;
    wait_rsp(base + 1, 20, "t3a_done");
    chk("t3a_lat", 64'(rsp_cyc - acc_cyc), 64'd1);
    px[3] = 32'd1;
    pend[3] = 1;
    wait_rsp(base + 2, 20, "t3b_done");
    chk("t3b_lat", 64'(rsp_cyc - acc_cyc), 64'd1);
    chk("t3_y0", 64'(act_y[0]), 64'd0);
    chk("t3_y1", 64'(act_y[1]), 64'd1);
    chk("t3_no_issue", 64'(n_issue - n0), 64'd0);

    // 4: requesters 0 and 1 held valid
    clear_obs();
    eng_fix = 0;
    base = n_rsp;
    keep[0] = 1; keep[1] = 1;
    px[0] = rand_x(); px[1] = rand_x();
    pend[0] = 1; pend[1] = 1;
    wait_rsp(base + 8, 400, "t4_done");
    for (int i = 0; i < 8; i++) chk("t4_alt", 64'(act_id[i]), 64'(i % 2));

    // 5: reset during WAIT, late engine pulse ignored
    do_reset();
    clear_obs();
    eng_fix = 10;
    n0 = n_issue;
    px[1] = 32'd1000;
    pend[1] = 1;
    k = 0;
    while (n_issue == n0 && k < 50) begin @(negedge clk); #1; k++; end
    chk("t5_issued", 64'(n_issue - n0), 64'd1);
    repeat (3) @(negedge clk);
    do_reset();
    repeat (15) @(negedge clk);
    #1;
    chk("t5_no_rsp", 64'(act_id.size()), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    base = n_rsp;
    px[3] = 32'd49; px[0] = 32'd64;
    pend[3] = 1; pend[0] = 1;
    wait_rsp(base + 2, 60, "t5_done");
    chk("t5_first", 64'(act_id[0]), 64'd0);
    chk("t5_y0", 64'(act_y[0]), 64'd8);
    chk("t5_y1", 64'(act_y[1]), 64'd7);

    // 6: engine never replies
    do_reset();
    clear_obs();
    eng_dead = 1;
    reply_at = -1;
    base = n_rsp;
    px[1] = 32'd50;
    pend[1] = 1;
`ifdef SQRT_ARB_TIMEOUT_EN
    wait_rsp(base + 1, TO + 40, "t6_done");
    chk("t6_lat", 64'(rsp_cyc - iss_cyc), 64'(TO + 1));
    chk("t6_y", 64'(act_y[0]), 64'hFFFF);
    chk("t6_err", 64'(act_err[0]), 64'd1);
`else
    repeat (200) @(negedge clk);
    #1;
    chk("t6_busy_hang", 64'(busy), 64'd1);
    chk("t6_no_rsp", 64'(act_id.size()), 64'd0);
`endif
    eng_dead = 0;

    // 7: randomized traffic with spurious engine pulses
    do_reset();
    eng_fix = 0;
    auto_en = 1;
    spur_en = 1;
    base = n_rsp;
    repeat (3000) @(negedge clk);
    auto_en = 0;
    spur_en = 0;
    k = 0;
    while ((m_act || pend[0] || pend[1] || pend[2] || pend[3]) && k < 2000) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("t7_drained", 64'(m_act), 64'd0);
    chk("t7_traffic", 64'(n_rsp - base > 50), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
